// File: rtl/mm_arb_pkg.sv
// Shared types and helpers for the memory-mapped lock arbiter.
package mm_arb_pkg;

    typedef enum logic {ARB_RR, ARB_FP} scheme_t;
    typedef enum logic {ST_IDLE, ST_OWN} state_t;

    localparam int CNTW = 8;

    function automatic scheme_t scheme_of(input logic [15:0] s);
        return (s == "FP") ? ARB_FP : ARB_RR;
    endfunction

    function automatic int num_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/mm_arb_select.sv
// Combinational one-hot winner picker: first requester found scanning upward
// (with wrap) from start, or from index 0 in fixed-priority mode.
module mm_arb_select
    import mm_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int NUMW = 1
) (
    input  logic [N-1:0]    req,
    input  logic [NUMW-1:0] start,
    input  logic            fp,
    output logic [N-1:0]    onehot,
    output logic [NUMW-1:0] num
);

    logic [NUMW:0]   pos;
    logic [NUMW-1:0] ix;
    logic            hit;

    always_comb begin
        onehot = '0;
        num    = '0;
        hit    = 1'b0;
        pos    = '0;
        ix     = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, (fp ? {NUMW{1'b0}} : start)} + (NUMW+1)'(k);
            if (pos >= (NUMW+1)'(N))
                pos = pos - (NUMW+1)'(N);
            ix = pos[NUMW-1:0];
            if (!hit && req[ix]) begin
                onehot[ix] = 1'b1;
                num        = ix;
                hit        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_arbitrator_lock.sv
// Memory-mapped arbiter: registered one-hot grant, held by s_lock or for up to
// QUANTUM accepted transactions while others wait; slave side is an AND-OR mux.
module mm_arbitrator_lock
    import mm_arb_pkg::*;
#(
    parameter int          AWIDTH  = 8,
    parameter int          DWIDTH  = 8,
    parameter int          MASTERS = 2,
    parameter logic [15:0] SCHEME  = "RR",
    parameter int          QUANTUM = 4,
    localparam int         NUMW    = num_w(MASTERS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MASTERS*AWIDTH-1:0] s_addr,
    input  logic [MASTERS-1:0]        s_wreq,
    input  logic [MASTERS*DWIDTH-1:0] s_wdat,
    input  logic [MASTERS-1:0]        s_rreq,
    input  logic [MASTERS-1:0]        s_lock,
    output logic [MASTERS*DWIDTH-1:0] s_rdat,
    output logic [MASTERS-1:0]        s_rdyn,
    output logic [AWIDTH-1:0]         m_addr,
    output logic                      m_wreq,
    output logic [DWIDTH-1:0]         m_wdat,
    output logic                      m_rreq,
    input  logic [DWIDTH-1:0]         m_rdat,
    input  logic                      m_rdyn,
    output logic                      gnt_vld,
    output logic [NUMW-1:0]           gnt_num
);

    localparam scheme_t        SCH  = scheme_of(SCHEME);
    localparam logic [CNTW-1:0] QMAX = CNTW'(QUANTUM);

    state_t              state;
    logic [MASTERS-1:0]  gnt;
    logic [CNTW-1:0]     cnt;
    logic [NUMW-1:0]     rr_ptr;

    logic [MASTERS-1:0]  req;
    logic [MASTERS-1:0]  sel_oh;
    logic [NUMW-1:0]     sel_num;
    logic [NUMW-1:0]     ptr_nxt;
    logic                any_req;
    logic                other_req;
    logic                own_req;
    logic                own_lock;
    logic                accept;
    logic [CNTW-1:0]     cnt_after;
    logic                q_hit;
    logic                rel;

    assign req       = s_wreq | s_rreq;
    assign any_req   = |req;
    assign other_req = |(req & ~gnt);

    always_comb begin
        m_addr   = '0;
        m_wdat   = '0;
        m_wreq   = 1'b0;
        m_rreq   = 1'b0;
        own_req  = 1'b0;
        own_lock = 1'b0;
        for (int i = 0; i < MASTERS; i++) begin
            m_addr   |= s_addr[i*AWIDTH +: AWIDTH] & {AWIDTH{gnt[i]}};
            m_wdat   |= s_wdat[i*DWIDTH +: DWIDTH] & {DWIDTH{gnt[i]}};
            m_wreq   |= s_wreq[i] & gnt[i];
            m_rreq   |= s_rreq[i] & gnt[i];
            own_req  |= req[i] & gnt[i];
            own_lock |= s_lock[i] & gnt[i];
        end
    end

    assign s_rdyn = ~gnt | {MASTERS{m_rdyn}};
    assign s_rdat = {MASTERS{m_rdat}};

    // Release decision sees this cycle's accept, so the QUANTUM-th transfer ends the tenure.
    assign accept    = gnt_vld & (m_wreq | m_rreq) & ~m_rdyn;
    assign cnt_after = (accept && cnt != {CNTW{1'b1}}) ? cnt + CNTW'(1) : cnt;
    assign q_hit     = cnt_after >= QMAX;
    assign rel       = ~own_lock & (~own_req | (q_hit & other_req));

    mm_arb_select #(.N(MASTERS), .NUMW(NUMW)) u_sel (
        .req    (req),
        .start  (rr_ptr),
        .fp     (SCH == ARB_FP),
        .onehot (sel_oh),
        .num    (sel_num)
    );

    assign ptr_nxt = (sel_num == NUMW'(MASTERS-1)) ? '0 : sel_num + NUMW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            gnt     <= '0;
            gnt_vld <= 1'b0;
            gnt_num <= '0;
            cnt     <= '0;
            rr_ptr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        state   <= ST_OWN;
                        gnt     <= sel_oh;
                        gnt_vld <= 1'b1;
                        gnt_num <= sel_num;
                        cnt     <= '0;
                        rr_ptr  <= ptr_nxt;
                    end
                end
                ST_OWN: begin
                    if (rel) begin
                        cnt <= '0;
                        if (any_req) begin
                            gnt     <= sel_oh;
                            gnt_num <= sel_num;
                            rr_ptr  <= ptr_nxt;
                        end else begin
                            state   <= ST_IDLE;
                            gnt     <= '0;
                            gnt_vld <= 1'b0;
                        end
                    end else if (~own_lock & q_hit & ~other_req) begin
                        // sole requester: fresh quantum instead of a pointless regrant
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_after;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
